memory_arbiter: RTL and testbench

//  Shares the single-port program/data RAM of the CPU between three requesters:

---
 rtl/puc_mem_pkg.sv | 21 ++
 rtl/memory_arbiter_arb_pick.sv | 33 +++
 rtl/memory_arbiter.sv | 147 ++++++++++++++
 tb/tb_memory_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/puc_mem_pkg.sv
// Shared types and constants for the program/data RAM arbiter.
package puc_mem_pkg;

    localparam int REGISTER_WIDTH = 16;
    localparam int LAT_CNT_W      = 3;
    localparam int NUM_REQ        = 3;

    typedef enum logic [1:0] {
        REQ_LOADER = 2'd0,
        REQ_DATA   = 2'd1,
        REQ_FETCH  = 2'd2
    } requester_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/memory_arbiter_arb_pick.sv
// Combinational grant selection: loader has absolute priority, data and fetch
// alternate on a tie and are masked entirely while the loader is active.
module arb_pick
    import puc_mem_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               loaderActive,
    input  requester_e         lastServed,
    output logic               grantValid,
    output requester_e         grantIdx
);

    always_comb begin
        grantValid = 1'b0;
        grantIdx   = REQ_LOADER;
        if (req[REQ_LOADER]) begin
            grantValid = 1'b1;
            grantIdx   = REQ_LOADER;
        end else if (!loaderActive) begin
            if (req[REQ_DATA] && req[REQ_FETCH]) begin
                grantValid = 1'b1;
                grantIdx   = (lastServed == REQ_DATA) ? REQ_FETCH : REQ_DATA;
            end else if (req[REQ_DATA]) begin
                grantValid = 1'b1;
                grantIdx   = REQ_DATA;
            end else if (req[REQ_FETCH]) begin
                grantValid = 1'b1;
                grantIdx   = REQ_FETCH;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Serialises loader, CPU data and CPU fetch accesses onto one single-port RAM:
// IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> ACK -> IDLE.
module memory_arbiter
    import puc_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = REGISTER_WIDTH,
    parameter int MEM_LATENCY = 1
) (
    input  logic                          clock,
    input  logic                          isReset,
    input  logic                          loaderActive,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            ack,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          busy,
    output logic                          memEnable,
    output logic                          memWriteEnable,
    output logic [ADDR_WIDTH-1:0]         memAddr,
    output logic [DATA_WIDTH-1:0]         memWdata,
    input  logic [DATA_WIDTH-1:0]         memRdata
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 7) begin : g_lat_chk
        $error("memory_arbiter: MEM_LATENCY must be within 1..7");
    end

    arb_state_e             state_q, state_d;
    requester_e             winner_q, winner_d;
    requester_e             lastServed_q, lastServed_d;
    logic                   weLat_q, weLat_d;
    logic [LAT_CNT_W-1:0]   waitCnt_q, waitCnt_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   memEn_q, memEn_d;
    logic                   memWe_q, memWe_d;
    logic [ADDR_WIDTH-1:0]  memAddr_q, memAddr_d;
    logic [DATA_WIDTH-1:0]  memWdata_q, memWdata_d;

    logic                   grantValid;
    requester_e             grantIdx;
    logic                   selWe;
    logic [ADDR_WIDTH-1:0]  selAddr;
    logic [DATA_WIDTH-1:0]  selWdata;

    arb_pick u_pick (
        .req          (req),
        .loaderActive (loaderActive),
        .lastServed   (lastServed_q),
        .grantValid   (grantValid),
        .grantIdx     (grantIdx)
    );

    assign selWe    = we[grantIdx];
    assign selAddr  = addr[int'(grantIdx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign selWdata = wdata[int'(grantIdx)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        lastServed_d = lastServed_q;
        weLat_d      = weLat_q;
        waitCnt_d    = waitCnt_q;
        ack_d        = '0;
        rdata_d      = rdata_q;
        memEn_d      = 1'b0;
        memWe_d      = 1'b0;
        memAddr_d    = memAddr_q;
        memWdata_d   = memWdata_q;
        unique case (state_q)
            IDLE: begin
                // Operands are captured here so the requester may change them afterwards.
                if (grantValid) begin
                    winner_d   = grantIdx;
                    weLat_d    = selWe;
                    memAddr_d  = selAddr;
                    memWdata_d = selWdata;
                    memEn_d    = 1'b1;
                    memWe_d    = selWe;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                waitCnt_d = LAT_CNT_W'(MEM_LATENCY);
                state_d   = WAIT;
            end
            WAIT: begin
                waitCnt_d = waitCnt_q - LAT_CNT_W'(1);
                if (waitCnt_q == LAT_CNT_W'(1)) begin
                    if (!weLat_q) begin
                        rdata_d = memRdata;
                    end
                    ack_d   = NUM_REQ'(1) << winner_q;
                    state_d = ACK;
                end
            end
            ACK: begin
                // The loader does not take part in the data/fetch rotation.
                if (winner_q != REQ_LOADER) begin
                    lastServed_d = winner_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (isReset) begin
            state_q      <= IDLE;
            winner_q     <= REQ_LOADER;
            lastServed_q <= REQ_FETCH;
            weLat_q      <= 1'b0;
            waitCnt_q    <= '0;
            ack_q        <= '0;
            rdata_q      <= '0;
            memEn_q      <= 1'b0;
            memWe_q      <= 1'b0;
            memAddr_q    <= '0;
            memWdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            lastServed_q <= lastServed_d;
            weLat_q      <= weLat_d;
            waitCnt_q    <= waitCnt_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            memEn_q      <= memEn_d;
            memWe_q      <= memWe_d;
            memAddr_q    <= memAddr_d;
            memWdata_q   <= memWdata_d;
        end
    end

    assign ack            = ack_q;
    assign rdata          = rdata_q;
    assign busy           = (state_q != IDLE);
    assign memEnable      = memEn_q;
    assign memWriteEnable = memWe_q;
    assign memAddr        = memAddr_q;
    assign memWdata       = memWdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a one-cycle-latency RAM model.
module tb_memory_arbiter;

    logic        clock = 1'b0;
    logic        isReset = 1'b1;
    logic        loaderActive = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [2:0]  we = 3'b000;
    logic [7:0]  a0 = 8'h00, a1 = 8'h00, a2 = 8'h00;
    logic [15:0] d0 = 16'h0, d1 = 16'h0, d2 = 16'h0;
    logic [2:0]  ack;
    logic [15:0] rdata;
    logic        busy;
    logic        memEnable;
    logic        memWriteEnable;
    logic [7:0]  memAddr;
    logic [15:0] memWdata;
    logic [15:0] memRdata;

    logic [15:0] ram [256];

    int nChk = 0;
    int nErr = 0;

    memory_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .MEM_LATENCY(1)) dut (
        .clock          (clock),
        .isReset        (isReset),
        .loaderActive   (loaderActive),
        .req            (req),
        .we             (we),
        .addr           ({a2, a1, a0}),
        .wdata          ({d2, d1, d0}),
        .ack            (ack),
        .rdata          (rdata),
        .busy           (busy),
        .memEnable      (memEnable),
        .memWriteEnable (memWriteEnable),
        .memAddr        (memAddr),
        .memWdata       (memWdata),
        .memRdata       (memRdata)
    );

    always #5 clock = ~clock;

    // RAM preload: word i holds 16'h1000+i, except word 8'h10 = 16'hBEEF.
    always @(posedge clock) begin
        if (isReset) begin
            for (int i = 0; i < 256; i++) ram[i] <= 16'h1000 + 16'(i);
            ram[8'h10] <= 16'hBEEF;
            memRdata   <= 16'h0;
        end else if (memEnable) begin
            if (memWriteEnable) ram[memAddr] <= memWdata;
            else                memRdata     <= ram[memAddr];
        end
    end

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  we;
        logic        la;
        logic [7:0]  a0, a1, a2;
        logic [15:0] d0, d1, d2;
        logic [2:0]  expAck;
        logic [15:0] expRd;
    } vec_t;

    vec_t vecs [12];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset;
        isReset = 1'b1;
        req = 3'b000;
        tick();
        isReset = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        req = v.req; we = v.we; loaderActive = v.la;
        a0 = v.a0; a1 = v.a1; a2 = v.a2;
        d0 = v.d0; d1 = v.d1; d2 = v.d2;
    endtask

    // Runs until ack or the budget expires; leaves the bench in the ack cycle.
    task automatic run_txn(input vec_t v, input int budget, output logic [2:0] ackv,
                           output int lat, output int enCnt, output int weCnt);
        drive(v);
        ackv = 3'b000; lat = 0; enCnt = 0; weCnt = 0;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if (memEnable) enCnt++;
            if (memWriteEnable) weCnt++;
            if (|ack) begin
                ackv = ack;
                lat  = c;
                break;
            end
        end
    endtask

    initial begin
        logic [2:0] ackv;
        int lat, enCnt, weCnt, lastAck, nAck;
        logic [2:0] expSeq [4];
        vec_t v;

        // Test 1: reset held two cycles with all requests asserted.
        isReset = 1'b1;
        req = 3'b111;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_ack", 32'(ack), 32'h0);
            chk("rst_memEnable", 32'(memEnable), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
        end
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_memAddr", 32'(memAddr), 32'h0);
        chk("rst_memWdata", 32'(memWdata), 32'h0);
        chk("rst_memWe", 32'(memWriteEnable), 32'h0);
        req = 3'b000;
        isReset = 1'b0;

        //          req     we     la    a0     a1     a2     d0        d1        d2        ack     rdata
        vecs[0]  = '{3'b100, 3'b000, 1'b0, 8'h00, 8'h00, 8'h10, 16'h0000, 16'h0000, 16'h0000, 3'b100, 16'hBEEF};
        vecs[1]  = '{3'b010, 3'b010, 1'b0, 8'h00, 8'h22, 8'h00, 16'h0000, 16'h1234, 16'h0000, 3'b010, 16'hBEEF};
        vecs[2]  = '{3'b010, 3'b000, 1'b0, 8'h00, 8'h22, 8'h00, 16'h0000, 16'h0000, 16'h0000, 3'b010, 16'h1234};
        vecs[3]  = '{3'b110, 3'b000, 1'b0, 8'h00, 8'h30, 8'h31, 16'h0000, 16'h0000, 16'h0000, 3'b100, 16'h1031};
        vecs[4]  = '{3'b110, 3'b000, 1'b0, 8'h00, 8'h30, 8'h31, 16'h0000, 16'h0000, 16'h0000, 3'b010, 16'h1030};
        vecs[5]  = '{3'b111, 3'b001, 1'b0, 8'h40, 8'h30, 8'h31, 16'h5555, 16'h0000, 16'h0000, 3'b001, 16'h1030};
        vecs[6]  = '{3'b001, 3'b000, 1'b0, 8'h40, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 3'b001, 16'h5555};
        vecs[7]  = '{3'b100, 3'b010, 1'b0, 8'h00, 8'h50, 8'h22, 16'h0000, 16'hDEAD, 16'h0000, 3'b100, 16'h1234};
        vecs[8]  = '{3'b110, 3'b000, 1'b1, 8'h00, 8'h50, 8'h22, 16'h0000, 16'h0000, 16'h0000, 3'b000, 16'h1234};
        vecs[9]  = '{3'b010, 3'b000, 1'b0, 8'h00, 8'h50, 8'h00, 16'h0000, 16'h0000, 16'h0000, 3'b010, 16'h1050};
        vecs[10] = '{3'b100, 3'b100, 1'b0, 8'h00, 8'h00, 8'h60, 16'h0000, 16'h0000, 16'h6666, 3'b100, 16'h1050};
        vecs[11] = '{3'b110, 3'b000, 1'b0, 8'h00, 8'h60, 8'h61, 16'h0000, 16'h0000, 16'h0000, 3'b010, 16'h6666};

        // Tests 2 and table: single transactions, round robin, masking, write qualification.
        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i], (vecs[i].expAck == 3'b000) ? 8 : 12, ackv, lat, enCnt, weCnt);
            chk($sformatf("vec%0d_ack", i), 32'(ackv), 32'(vecs[i].expAck));
            chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].expRd));
            if (vecs[i].expAck != 3'b000) begin
                chk($sformatf("vec%0d_latency", i), lat, 3);
                chk($sformatf("vec%0d_memEnable_cycles", i), enCnt, 1);
                chk($sformatf("vec%0d_memWe_cycles", i), weCnt,
                    int'(|(vecs[i].we & vecs[i].expAck)));
            end else begin
                chk($sformatf("vec%0d_memEnable_cycles", i), enCnt, 0);
                chk($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
            end
            req = 3'b000;
            loaderActive = 1'b0;
            tick();
        end

        // Test 3: data and fetch requesting continuously from reset.
        do_reset();
        expSeq[0] = 3'b010; expSeq[1] = 3'b100; expSeq[2] = 3'b010; expSeq[3] = 3'b100;
        req = 3'b110; we = 3'b000; a1 = 8'h70; a2 = 8'h71;
        nAck = 0; lastAck = 0;
        for (int c = 1; c <= 40 && nAck < 4; c++) begin
            tick();
            if (|ack) begin
                chk($sformatf("rr_ack%0d", nAck), 32'(ack), 32'(expSeq[nAck]));
                chk($sformatf("rr_rdata%0d", nAck), 32'(rdata),
                    (expSeq[nAck] == 3'b010) ? 32'h1070 : 32'h1071);
                if (nAck > 0) chk($sformatf("rr_spacing%0d", nAck), c - lastAck, 4);
                lastAck = c;
                nAck++;
                if (nAck == 4) req = 3'b000;
            end
        end
        chk("rr_ack_count", nAck, 4);
        tick();

        // Test 4: loader downloads ten words while data and fetch are locked out.
        for (int i = 0; i < 10; i++) begin
            v = '{3'b111, 3'b001, 1'b1, 8'(i), 8'h80, 8'h81, 16'(i + 1), 16'h0, 16'h0, 3'b001, 16'h0};
            run_txn(v, 12, ackv, lat, enCnt, weCnt);
            chk($sformatf("load%0d_ack", i), 32'(ackv), 32'h1);
            req = 3'b000;
            tick();
        end
        loaderActive = 1'b0;
        for (int i = 0; i < 10; i++) begin
            v = '{3'b001, 3'b000, 1'b0, 8'(i), 8'h00, 8'h00, 16'h0, 16'h0, 16'h0, 3'b001, 16'h0};
            run_txn(v, 12, ackv, lat, enCnt, weCnt);
            chk($sformatf("readback%0d_ack", i), 32'(ackv), 32'h1);
            chk($sformatf("readback%0d_rdata", i), 32'(rdata), 32'(i + 1));
            req = 3'b000;
            tick();
        end

        // Test 5: loader raises req while a data write is in flight.
        req = 3'b010; we = 3'b010; a1 = 8'h20; d1 = 16'h1234;
        tick();
        chk("inflight_memWe", 32'(memWriteEnable), 32'h1);
        req = 3'b011; a0 = 8'h20; a1 = 8'h99; d1 = 16'hFFFF;
        ackv = 3'b000; lastAck = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (|ack) begin ackv = ack; lastAck = c; break; end
        end
        chk("inflight_first_ack", 32'(ackv), 32'h2);
        req = 3'b001; we = 3'b000;
        ackv = 3'b000; lat = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (|ack) begin ackv = ack; lat = c; break; end
        end
        chk("inflight_loader_ack", 32'(ackv), 32'h1);
        chk("inflight_loader_spacing", lat, 4);
        chk("inflight_ram20", 32'(rdata), 32'h1234);
        req = 3'b000;
        tick();

        // Test 6: reset during WAIT drops the transaction.
        req = 3'b100; we = 3'b000; a2 = 8'h10;
        tick();
        chk("rstwait_memEnable", 32'(memEnable), 32'h1);
        tick();
        chk("rstwait_busy_before", 32'(busy), 32'h1);
        req = 3'b000;
        isReset = 1'b1;
        tick();
        isReset = 1'b0;
        chk("rstwait_busy_after", 32'(busy), 32'h0);
        chk("rstwait_ack_after", 32'(ack), 32'h0);
        chk("rstwait_rdata_after", 32'(rdata), 32'h0);
        nAck = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (|ack) nAck++;
        end
        chk("rstwait_no_late_ack", nAck, 0);
        v = '{3'b100, 3'b000, 1'b0, 8'h00, 8'h00, 8'h10, 16'h0, 16'h0, 16'h0, 3'b100, 16'h0};
        run_txn(v, 12, ackv, lat, enCnt, weCnt);
        chk("rstwait_next_ack", 32'(ackv), 32'h4);
        chk("rstwait_next_latency", lat, 3);
        chk("rstwait_next_rdata", 32'(rdata), 32'hBEEF);
        req = 3'b000;
        tick();

        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end

endmodule
